// File: rtl/ship_pkg.sv
// Shared types and helpers for the ship/enemy/bullet movers: headings,
// keycodes, heading-to-vector mapping and single-axis toroidal stepping.
package ship_pkg;

  typedef enum logic [2:0] {
    UP         = 3'd0,
    UP_RIGHT   = 3'd1,
    RIGHT      = 3'd2,
    DOWN_RIGHT = 3'd3,
    DOWN       = 3'd4,
    DOWN_LEFT  = 3'd5,
    LEFT       = 3'd6,
    UP_LEFT    = 3'd7
  } dir_t;

  // Screen coordinates: +dx is right, +dy is down.
  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } vec_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic vec_t dir_to_vec(input dir_t d);
    vec_t v;
    v.dx = 2'sd0;
    v.dy = 2'sd0;
    case (d)
      UP:         begin v.dx =  2'sd0; v.dy = -2'sd1; end
      UP_RIGHT:   begin v.dx =  2'sd1; v.dy = -2'sd1; end
      RIGHT:      begin v.dx =  2'sd1; v.dy =  2'sd0; end
      DOWN_RIGHT: begin v.dx =  2'sd1; v.dy =  2'sd1; end
      DOWN:       begin v.dx =  2'sd0; v.dy =  2'sd1; end
      DOWN_LEFT:  begin v.dx = -2'sd1; v.dy =  2'sd1; end
      LEFT:       begin v.dx = -2'sd1; v.dy =  2'sd0; end
      UP_LEFT:    begin v.dx = -2'sd1; v.dy = -2'sd1; end
      default:    begin v.dx =  2'sd0; v.dy =  2'sd0; end
    endcase
    return v;
  endfunction

  // Only meaningful for a non-zero vector; callers gate on that.
  function automatic dir_t vec_to_dir(input vec_t v);
    logic [3:0] bits;
    dir_t       d;
    bits = v;
    case (bits)
      4'b0011: d = UP;
      4'b0111: d = UP_RIGHT;
      4'b0100: d = RIGHT;
      4'b0101: d = DOWN_RIGHT;
      4'b0001: d = DOWN;
      4'b1101: d = DOWN_LEFT;
      4'b1100: d = LEFT;
      4'b1111: d = UP_LEFT;
      default: d = UP;
    endcase
    return d;
  endfunction

  // Move one axis by +/-step with wrap into [lo, hi]. The decrement path adds
  // the span before subtracting so the 11-bit intermediate never underflows.
  function automatic logic [9:0] axis_step(input logic [10:0]       pos,
                                           input logic signed [1:0] d,
                                           input logic [10:0]       lo,
                                           input logic [10:0]       hi,
                                           input logic [10:0]       step);
    logic [10:0] span;
    logic [10:0] res;
    span = hi - lo + 11'd1;
    res  = pos;
    if (d == 2'sd1) begin
      res = pos + step;
      if (res > hi) res = res - span;
    end else if (d == -2'sd1) begin
      if (pos < lo + step) res = pos + span - step;
      else                 res = pos - step;
    end
    return res[9:0];
  endfunction

endpackage

// File: rtl/ship_motion_vsync_edge.sv
// Brings the (possibly asynchronous) vsync strobe into the Clk domain and
// turns each rising edge into a one-cycle frame_tick.
module vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic s1;
  logic s2;
  logic s3;

  // Flops reset high so a vsync already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      s3         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      s1         <= frame_clk;
      s2         <= s1;
      s3         <= s2;
      frame_tick <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/ship_motion.sv
// Player-ship position/heading controller: WASD keys steer one of 8 headings,
// the ship advances STEP pixels per frame and wraps at the screen edges.
module ship_motion
  import ship_pkg::*;
#(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 479,
  parameter int X_START = 320,
  parameter int Y_START = 240,
  parameter int STEP    = 2,
  parameter int SIZE    = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] ShipX,
  output logic [9:0] ShipY,
  output logic [9:0] Ship_size,
  output logic [2:0] heading,
  output logic       frame_tick
);

  localparam logic [10:0] X_LO   = 11'(X_MIN);
  localparam logic [10:0] X_HI   = 11'(X_MAX);
  localparam logic [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic [10:0] Y_HI   = 11'(Y_MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);

  dir_t       heading_q;
  vec_t       key_vec;
  logic       key_move;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  vec_t       move_vec;
  logic [9:0] next_x;
  logic [9:0] next_y;

  vsync_edge u_vsync_edge (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  always_comb begin
    key_up    = (keycode0 == KEY_W) || (keycode1 == KEY_W);
    key_down  = (keycode0 == KEY_S) || (keycode1 == KEY_S);
    key_left  = (keycode0 == KEY_A) || (keycode1 == KEY_A);
    key_right = (keycode0 == KEY_D) || (keycode1 == KEY_D);

    key_vec.dx = 2'sd0;
    key_vec.dy = 2'sd0;
    if (key_right && !key_left)      key_vec.dx =  2'sd1;
    else if (key_left && !key_right) key_vec.dx = -2'sd1;
    if (key_down && !key_up)         key_vec.dy =  2'sd1;
    else if (key_up && !key_down)    key_vec.dy = -2'sd1;

    key_move = (key_vec.dx != 2'sd0) || (key_vec.dy != 2'sd0);
  end

  // No keys (or cancelling keys) keeps the last heading: the ship never stops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      heading_q <= UP;
    else if (key_move) heading_q <= vec_to_dir(key_vec);
  end

  // Motion reads the registered heading, so a key change landing on the same
  // cycle as a tick only takes effect from the next frame.
  always_comb begin
    move_vec = dir_to_vec(heading_q);
    next_x   = axis_step({1'b0, ShipX}, move_vec.dx, X_LO, X_HI, STEP_W);
    next_y   = axis_step({1'b0, ShipY}, move_vec.dy, Y_LO, Y_HI, STEP_W);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ShipX <= 10'(X_START);
      ShipY <= 10'(Y_START);
    end else if (frame_tick && enable) begin
      ShipX <= next_x;
      ShipY <= next_y;
    end
  end

  assign heading   = heading_q;
  assign Ship_size = 10'(SIZE);

endmodule

// File: tb/tb_ship_motion.sv
// Directed self-checking bench for ship_motion; a second instance starts next
// to the edges so the exact X=638 / Y=1 wrap cases are reachable in one frame.
module tb_ship_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clk = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] key0 = 8'h00;
  logic [7:0] key1 = 8'h00;
  logic [9:0] ship_x, ship_y, ship_size;
  logic [2:0] heading;
  logic       frame_tick;

  logic       rst_b_n = 1'b0;
  logic       enable_b = 1'b0;
  logic [7:0] kb0 = 8'h00;
  logic [9:0] ship_x_b, ship_y_b, ship_size_b;
  logic [2:0] heading_b;
  logic       frame_tick_b;

  int vectors = 0;
  int miscompares = 0;
  int tick_cnt = 0;
  int t0;

  always #5 clk = ~clk;

  ship_motion u_dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .enable(enable),
    .keycode0(key0), .keycode1(key1),
    .ShipX(ship_x), .ShipY(ship_y), .Ship_size(ship_size),
    .heading(heading), .frame_tick(frame_tick)
  );

  ship_motion #(.X_START(638), .Y_START(1)) u_dut_b (
    .Clk(clk), .Reset_n(rst_b_n), .frame_clk(frame_clk), .enable(enable_b),
    .keycode0(kb0), .keycode1(8'h00),
    .ShipX(ship_x_b), .ShipY(ship_y_b), .Ship_size(ship_size_b),
    .heading(heading_b), .frame_tick(frame_tick_b)
  );

  always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic do_frame();
    @(negedge clk) frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = tick_cnt;
    repeat (6) @(negedge clk);
    vectors++; if (tick_cnt - t0 !== 0) begin miscompares++; $display("FAIL reset_no_tick got %0d ticks exp 0", tick_cnt - t0); end
    vectors++; if (ship_x !== 10'd320) begin miscompares++; $display("FAIL reset_x got %0d exp 320", ship_x); end
    vectors++; if (ship_y !== 10'd240) begin miscompares++; $display("FAIL reset_y got %0d exp 240", ship_y); end
    vectors++; if (heading !== 3'd0) begin miscompares++; $display("FAIL reset_heading got %0d exp 0", heading); end
    vectors++; if (ship_size !== 10'd4) begin miscompares++; $display("FAIL reset_size got %0d exp 4", ship_size); end
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_right_one_frame();
    key0 = 8'h07;
    @(negedge clk);
    vectors++; if (heading !== 3'd2) begin miscompares++; $display("FAIL right_heading got %0d exp 2", heading); end
    t0 = tick_cnt;
    frame_clk = 1'b1;
    @(negedge clk);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL tick_k got %b exp 0", frame_tick); end
    @(negedge clk);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL tick_k1 got %b exp 0", frame_tick); end
    @(negedge clk);
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL tick_k2 got %b exp 1", frame_tick); end
    vectors++; if (ship_x !== 10'd320) begin miscompares++; $display("FAIL x_before_move got %0d exp 320", ship_x); end
    @(negedge clk);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL tick_k3 got %b exp 0", frame_tick); end
    vectors++; if (ship_x !== 10'd322) begin miscompares++; $display("FAIL right_x got %0d exp 322", ship_x); end
    vectors++; if (ship_y !== 10'd240) begin miscompares++; $display("FAIL right_y got %0d exp 240", ship_y); end
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (tick_cnt - t0 !== 1) begin miscompares++; $display("FAIL right_tick_count got %0d exp 1", tick_cnt - t0); end
    key0 = 8'h00;
  endtask

  task automatic test_diagonal();
    do_reset();
    key0 = 8'h1A; key1 = 8'h04;
    @(negedge clk);
    vectors++; if (heading !== 3'd7) begin miscompares++; $display("FAIL diag_heading got %0d exp 7", heading); end
    repeat (3) do_frame();
    vectors++; if (ship_x !== 10'd314) begin miscompares++; $display("FAIL diag_x got %0d exp 314", ship_x); end
    vectors++; if (ship_y !== 10'd234) begin miscompares++; $display("FAIL diag_y got %0d exp 234", ship_y); end
    key0 = 8'h00; key1 = 8'h00;
    do_frame();
    vectors++; if (heading !== 3'd7) begin miscompares++; $display("FAIL coast_heading got %0d exp 7", heading); end
    vectors++; if (ship_x !== 10'd312) begin miscompares++; $display("FAIL coast_x got %0d exp 312", ship_x); end
    vectors++; if (ship_y !== 10'd232) begin miscompares++; $display("FAIL coast_y got %0d exp 232", ship_y); end
  endtask

  task automatic test_opposite_keys();
    key0 = 8'h07; key1 = 8'h00;
    @(negedge clk);
    key0 = 8'h1A; key1 = 8'h16;
    repeat (2) @(negedge clk);
    vectors++; if (heading !== 3'd2) begin miscompares++; $display("FAIL opposite_heading got %0d exp 2", heading); end
    key1 = 8'h07;
    @(negedge clk);
    vectors++; if (heading !== 3'd1) begin miscompares++; $display("FAIL up_right_heading got %0d exp 1", heading); end
    key0 = 8'h00; key1 = 8'h00;
  endtask

  task automatic test_wrap();
    @(negedge clk) rst_b_n = 1'b1;
    kb0 = 8'h07;
    @(negedge clk);
    enable_b = 1'b1;
    do_frame();
    vectors++; if (ship_x_b !== 10'd0) begin miscompares++; $display("FAIL wrap_x_638 got %0d exp 0", ship_x_b); end
    vectors++; if (ship_y_b !== 10'd1) begin miscompares++; $display("FAIL wrap_x_638_y got %0d exp 1", ship_y_b); end
    kb0 = 8'h1A;
    @(negedge clk);
    do_frame();
    vectors++; if (ship_y_b !== 10'd479) begin miscompares++; $display("FAIL wrap_y_1 got %0d exp 479", ship_y_b); end
    vectors++; if (ship_x_b !== 10'd0) begin miscompares++; $display("FAIL wrap_y_1_x got %0d exp 0", ship_x_b); end
    enable_b = 1'b0; kb0 = 8'h00;

    do_reset();
    key0 = 8'h07;
    @(negedge clk);
    key0 = 8'h00;
    repeat (159) do_frame();
    vectors++; if (ship_x !== 10'd638) begin miscompares++; $display("FAIL run_x got %0d exp 638", ship_x); end
    do_frame();
    vectors++; if (ship_x !== 10'd0) begin miscompares++; $display("FAIL run_wrap_x got %0d exp 0", ship_x); end
    key0 = 8'h1A;
    @(negedge clk);
    key0 = 8'h00;
    repeat (120) do_frame();
    vectors++; if (ship_y !== 10'd0) begin miscompares++; $display("FAIL run_y got %0d exp 0", ship_y); end
    do_frame();
    vectors++; if (ship_y !== 10'd478) begin miscompares++; $display("FAIL run_wrap_y got %0d exp 478", ship_y); end
    vectors++; if (ship_x !== 10'd0) begin miscompares++; $display("FAIL run_wrap_y_x got %0d exp 0", ship_x); end
  endtask

  task automatic test_enable_and_reset();
    do_reset();
    enable = 1'b0;
    key0 = 8'h07;
    @(negedge clk);
    key0 = 8'h00;
    vectors++; if (heading !== 3'd2) begin miscompares++; $display("FAIL disabled_heading got %0d exp 2", heading); end
    t0 = tick_cnt;
    repeat (5) do_frame();
    vectors++; if (ship_x !== 10'd320) begin miscompares++; $display("FAIL disabled_x got %0d exp 320", ship_x); end
    vectors++; if (ship_y !== 10'd240) begin miscompares++; $display("FAIL disabled_y got %0d exp 240", ship_y); end
    vectors++; if (tick_cnt - t0 !== 5) begin miscompares++; $display("FAIL disabled_ticks got %0d exp 5", tick_cnt - t0); end
    enable = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (ship_x !== 10'd320) begin miscompares++; $display("FAIL no_deferred_move got %0d exp 320", ship_x); end
    do_frame();
    vectors++; if (ship_x !== 10'd322) begin miscompares++; $display("FAIL reenabled_x got %0d exp 322", ship_x); end

    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (ship_x !== 10'd320) begin miscompares++; $display("FAIL async_rst_x got %0d exp 320", ship_x); end
    vectors++; if (ship_y !== 10'd240) begin miscompares++; $display("FAIL async_rst_y got %0d exp 240", ship_y); end
    vectors++; if (heading !== 3'd0) begin miscompares++; $display("FAIL async_rst_heading got %0d exp 0", heading); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL async_rst_tick got %b exp 0", frame_tick); end
    @(negedge clk) rst_n = 1'b1;
    t0 = tick_cnt;
    repeat (4) @(negedge clk);
    vectors++; if (tick_cnt - t0 !== 0) begin miscompares++; $display("FAIL post_rst_no_tick got %0d exp 0", tick_cnt - t0); end
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    do_frame();
    vectors++; if (tick_cnt - t0 !== 1) begin miscompares++; $display("FAIL post_rst_first_tick got %0d exp 1", tick_cnt - t0); end
    vectors++; if (ship_y !== 10'd238) begin miscompares++; $display("FAIL post_rst_y got %0d exp 238", ship_y); end
    vectors++; if (ship_x !== 10'd320) begin miscompares++; $display("FAIL post_rst_x got %0d exp 320", ship_x); end
  endtask

  initial begin
    test_reset();
    test_right_one_frame();
    test_diagonal();
    test_opposite_keys();
    test_wrap();
    test_enable_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ship_motion.md
Name: ship_motion

Overview:
Player-ship position and heading controller for the Bosconian game.
- Consumes keyboard keycodes and the per-frame vertical-sync strobe.
- Advances the ship once per video frame in one of 8 headings, with toroidal wrap-around at the screen edges.
- Drives ShipX/ShipY/Ship_size into the colour mapper's BallX/BallY/Ball_size inputs. The colour mapper sits directly downstream.

Parameters:
X_MIN, 0, leftmost legal ship X (pixels)
X_MAX, 639, rightmost legal ship X
Y_MIN, 0, topmost legal ship Y
Y_MAX, 479, bottommost legal ship Y
X_START, 320, ship X after reset
Y_START, 240, ship Y after reset
STEP, 2, pixels moved per frame per axis; must satisfy 1 <= STEP < (X_MAX-X_MIN+1) and STEP < (Y_MAX-Y_MIN+1)
SIZE, 4, ship radius driven on Ship_size

Ports:
Clk  in  1  system clock (50 MHz); all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  vertical-sync strobe from VGA controller; may be asynchronous to Clk
enable  in  1  1 = ship moves on frame ticks; 0 = position frozen, heading still updates
keycode0  in  8  first held USB HID keycode (0x00 = none)
keycode1  in  8  second held USB HID keycode (0x00 = none)
ShipX  out  10  ship centre X
ShipY  out  10  ship centre Y
Ship_size  out  10  constant SIZE
heading  out  3  current heading, encoded as dir_t
frame_tick  out  1  one-Clk pulse per frame_clk rising edge

Behaviour:
- Reset (Reset_n low, asynchronous):
  - ShipX=X_START, ShipY=Y_START, heading=UP (3'd0), frame_tick=0.
  - Synchronizer flops are set to 1, so no tick fires on reset release even when frame_clk is high.
  - Ship_size is combinationally SIZE at all times.
- frame_clk path:
  - 2-flop synchronizer (s1, s2), then delay flop s3.
  - frame_tick is registered: frame_tick <= s2 & ~s3.
  - A rising edge first captured by s1 at Clk edge k produces frame_tick high for exactly one cycle, from edge k+2 to edge k+3.
  - Position updates at edge k+3.
- Key decode, combinational, on either keycode:
  - W 0x1A = up, S 0x16 = down, A 0x04 = left, D 0x07 = right.
  - Vertical component: up&~down → -1, down&~up → +1, otherwise 0. Horizontal likewise for right/left.
  - Other keycodes are ignored.
- Heading register:
  - Each Clk, if the decoded (dx,dy) is non-zero, heading <= matching dir_t: UP, UP_RIGHT, RIGHT, DOWN_RIGHT, DOWN, DOWN_LEFT, LEFT, UP_LEFT (0..7).
  - If (dx,dy)=(0,0), heading holds. The ship never stops; it keeps flying on the last heading.
- Motion (on frame_tick & enable only; otherwise ShipX/ShipY hold):
  - Apply the per-axis unit vector of heading × STEP.
  - X + STEP: if the result exceeds X_MAX, new X = X + STEP - (X_MAX-X_MIN+1).
  - X - STEP: if X < X_MIN+STEP, new X = X - STEP + (X_MAX-X_MIN+1).
  - Y uses the same rules with Y_MIN/Y_MAX.
  - Compute in 11-bit unsigned intermediates; no underflow below 0.
- Simultaneous events: a heading change and frame_tick in the same cycle use the old (registered) heading for that frame's move.
- enable low on a tick: the tick is consumed and no deferred move happens.
- Reset mid-frame: all state clears immediately; the first frame_clk rising edge fully after release produces the first tick.

Decomposition:
- ship_pkg:
  - dir_t (3-bit enum UP..UP_LEFT)
  - keycode constants KEY_W/KEY_A/KEY_S/KEY_D
  - function dir_to_vec (dir_t → signed dx,dy)
- Sub-module vsync_edge: synchronizer + edge detect producing frame_tick, reset-to-1 flops. It is reused by the enemy/bullet movers.

Test Plan:
- Reset release with frame_clk held high → no frame_tick; ShipX=320, ShipY=240, heading=0, Ship_size=4.
- keycode0=0x07, one frame_clk pulse → heading=2 one cycle after the key; frame_tick pulses exactly once, 2 edges after capture; ShipX=322, ShipY=240.
- keycode0=0x1A, keycode1=0x04, 3 frames → heading=7, ShipX=314, ShipY=234. Then both keys released, 1 frame → heading stays 7, (312,232).
- Wrap: ShipX=638 heading RIGHT, 1 frame → ShipX=0. ShipY=1 heading UP, 1 frame → ShipY=479.
- keycode0=0x1A, keycode1=0x16 (opposites) with heading=2 → heading stays 2. keycode0=0x1A, keycode1=0x07 → heading=1.
- enable=0 across 5 frames → position unchanged, frame_tick still pulses 5 times. Reset_n asserted mid-move → outputs return to (320,240,UP) without waiting for a Clk edge.
